mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Multicycle memory stage downstream of the CPU datapath.
//  Accepts word read/write requests driven by the controller's MemRead/MemWrite and the datapath address/write data.
//  Models a word RAM with fixed access latency and returns read data with a one-cycle completion pulse.
//  The controller holds its memory state until mem_ready.
// PARAMETERS
//  DATA_W   32   data word width
//  DEPTH    256  number of words in the RAM
//  ADDR_W   8    word-index width; 2**ADDR_W == DEPTH
//  LATENCY  2    cycles from request accept to completion; legal range 1..15
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  mem_read   in   1       read request (level)
//  mem_write  in   1       write request (level)
//  addr       in   32      byte address; word index = addr[ADDR_W+1:2]
//  wdata      in   DATA_W  write data, sampled at accept
//  rdata      out  DATA_W  read data, valid while mem_ready=1 and held until the next read completes
//  mem_ready  out  1       one-cycle completion pulse
//  busy       out  1       high from the accept cycle through the completion cycle
//  mem_err    out  1       access error, valid with mem_ready (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cnt=0, rdata=0, mem_ready=0, busy=0, mem_err=0.
//   RAM contents are not cleared.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//   - Accept when (mem_read|mem_write)=1.
//   - Latch op, word index and wdata; cnt <= LATENCY-1; go to WAIT; busy=1 from the next edge.
//   - mem_read and mem_write both high: treated as a write. Write wins.
//  WAIT:
//   - cnt != 0: cnt <= cnt-1.
//   - cnt == 0:
//     - write: RAM[idx] <= wdata.
//     - read: rdata <= RAM[idx].
//     - Set mem_ready=1 and go to RESP.
//  RESP:
//   - mem_ready=1 for exactly this cycle, then IDLE with mem_ready=0 and busy=0.
//   - Requests present in RESP are ignored. The earliest re-accept is the following IDLE cycle.
//  Latency: accept at edge N; mem_ready is high in the cycle after edge N+LATENCY.
//   - LATENCY=1: ready 2 cycles after the request is first seen.
//  Request inputs are ignored outside IDLE. addr, wdata and op changes after accept have no effect.
//  A request dropped before accept is never started. Once accepted, a request always completes unless reset.
//  Write-then-read of the same index returns the new data.
//  Reset mid-operation: the pending write is discarded (RAM unchanged) and no mem_ready is issued.
// CONFIGURATION
//  MEM_ACCESS_ERR_EN defined:
//   - mem_err=1 with mem_ready when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
//   - On error, the write is suppressed, rdata is forced to 0, and latency is unchanged.
//  MEM_ACCESS_ERR_EN undefined:
//   - mem_err tied to 0.
//   - addr[1:0] ignored; upper bits ignored, so the index wraps modulo DEPTH.
// TESTING
//  1 Reset: assert reset=0 mid-WAIT of a write to addr 0x10 -> outputs 0, no mem_ready; later read 0x10 returns old data.
//  2 Write 0xDEADBEEF @0x04, then read 0x04 (LATENCY=2) -> mem_ready 3 cycles after each request, rdata=0xDEADBEEF.
//  3 mem_read=mem_write=1, wdata=0x12345678 @0x08 -> write performed; subsequent read of 0x08 = 0x12345678.
//  4 Requests held high through RESP -> exactly one mem_ready per accepted access, next accept in IDLE; busy pattern checked.
//  5 No ERR_EN: write 0xA5A5A5A5 @0x400 (DEPTH=256) -> read @0x000 returns 0xA5A5A5A5 (wrap).
//  6 ERR_EN: read @0x06 or @0x400 -> mem_err=1, rdata=0; write @0x401 -> mem_err=1, RAM unchanged.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Request/response bundle between the CPU memory controller and the memory
// access stage.
//   mem_read / mem_write : level request strobes (write wins when both set)
//   addr                 : byte address, word index = addr[ADDR_W+1:2]
//   wdata                : write data, sampled when the request is accepted
//   rdata                : read data, held until the next read completes
//   mem_ready            : one-cycle completion pulse
//   busy                 : high from the accept cycle through the completion cycle
//   mem_err              : access error flag, valid together with mem_ready
// Modports: master (controller side), slave (memory stage side).
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              mem_err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, mem_ready, busy, mem_err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, mem_ready, busy, mem_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Multicycle memory stage: word RAM with a fixed access latency. A request is
// accepted in IDLE, waits LATENCY cycles, completes with a one-cycle mem_ready
// pulse and then returns to IDLE.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : mem_access_unit_if.slave (request, response and status signals)
// Parameters: DATA_W, DEPTH, ADDR_W (2**ADDR_W == DEPTH), LATENCY (1..15).
// Optional feature macro: MEM_ACCESS_ERR_EN
//   defined   : misaligned or out-of-range addresses complete with mem_err=1,
//               the write is suppressed and read data is forced to zero.
//   undefined : mem_err is always 0 and the word index wraps modulo DEPTH.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input logic                clk,
  input logic                reset,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_acc_err;   // error decided at accept, applied at completion
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic              r_mem_err;

  // RAM contents survive reset, so the array lives in its own unreset block.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_req;
  logic w_addr_err;
  logic w_done;
  logic w_ram_we;

  assign w_req = bus.mem_read | bus.mem_write;

`ifdef MEM_ACCESS_ERR_EN
  assign w_addr_err = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_W+2] != '0);
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_ram_we = w_done && r_is_write && !r_acc_err;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_acc_err  <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready   <= 1'b0;
          r_mem_err <= 1'b0;
          if (w_req) begin
            // Write has priority when both strobes are high.
            r_is_write <= bus.mem_write;
            r_idx      <= bus.addr[ADDR_W+1:2];
            r_wdata    <= bus.wdata;
            r_acc_err  <= w_addr_err;
            r_cnt      <= 4'(LATENCY - 1);
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_is_write) begin
              r_rdata <= r_acc_err ? '0 : r_mem[r_idx];
            end
            r_mem_err <= r_acc_err;
            r_ready   <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          // Requests seen here are ignored; re-accept happens from IDLE.
          r_ready   <= 1'b0;
          r_mem_err <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(32)) bus ();

  mem_access_unit #(
    .DATA_W (32),
    .DEPTH  (256),
    .ADDR_W (8),
    .LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word array with known-valid flags plus the last read value.
  logic [31:0] m_mem [256];
  bit          m_vld [256];
  logic [31:0] m_rdata;

  function automatic bit addr_err(input logic [31:0] a);
`ifdef MEM_ACCESS_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Drives one request and reports what the DUT did; callers compare.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] wd, input bit scramble,
                           output int lat, output logic [31:0] rdata_o,
                           output logic err_o, output int busy_bad,
                           output logic idle_busy);
    bit got;
    @(negedge clk);
    idle_busy = bus.busy;
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.addr      = a;
    bus.wdata     = wd;
    lat = 0;
    got = 0;
    busy_bad = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && scramble) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = $urandom;
        bus.wdata     = $urandom;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.mem_ready === 1'b1) got = 1;
    end
    rdata_o = bus.rdata;
    err_o   = bus.mem_err;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (!got) lat = -1;
    $display("txn wr=%0b rd=%0b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b",
             wr, rd, a, wd, lat, rdata_o, err_o);
  endtask

  task automatic model_apply(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    if (wr) begin
      if (!addr_err(a)) begin
        m_mem[idx_of(a)] = wd;
        m_vld[idx_of(a)] = 1;
      end
    end else begin
      m_rdata = addr_err(a) ? 32'd0 : m_mem[idx_of(a)];
    end
  endtask

  task automatic test_reset();
    int lat, bb; logic [31:0] rv; logic ev, ib;
    bit saw_ready;
    reset = 1'b0;
    bus.mem_read = 0; bus.mem_write = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.rdata, bus.mem_ready, bus.busy, bus.mem_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%08h rdy=%0b busy=%0b err=%0b, want all 0",
               bus.rdata, bus.mem_ready, bus.busy, bus.mem_err);
    end
    reset = 1'b1;
    m_rdata = 32'd0;
    do_access(1, 0, 32'h10, 32'h0BADF00D, 0, lat, rv, ev, bb, ib);
    model_apply(1, 32'h10, 32'h0BADF00D);
    n_chk++;
    if (lat !== LAT + 1) begin
      n_fail++; $display("FAIL reset_prewrite_lat: got %0d want %0d", lat, LAT + 1);
    end
    // Start a write of new data and reset it while in WAIT.
    @(negedge clk);
    bus.mem_write = 1; bus.addr = 32'h10; bus.wdata = 32'h77777777;
    @(negedge clk);
    bus.mem_write = 0;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.rdata, bus.mem_ready, bus.busy, bus.mem_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_midop_outputs: got rdata=%08h rdy=%0b busy=%0b err=%0b, want all 0",
               bus.rdata, bus.mem_ready, bus.busy, bus.mem_err);
    end
    saw_ready = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) saw_ready = 1;
    end
    reset = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) saw_ready = 1;
    end
    n_chk++;
    if (saw_ready) begin
      n_fail++; $display("FAIL reset_no_ready: got mem_ready=1 want 0");
    end
    m_rdata = 32'd0;
    do_access(0, 1, 32'h10, 32'h0, 0, lat, rv, ev, bb, ib);
    model_apply(0, 32'h10, 32'h0);
    n_chk++;
    if (rv !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL reset_old_data: got %08h want %08h", rv, 32'h0BADF00D);
    end
  endtask

  task automatic test_write_read();
    int lat, bb; logic [31:0] rv; logic ev, ib;
    logic [31:0] prev;
    prev = m_rdata;
    do_access(1, 0, 32'h04, 32'hDEADBEEF, 1, lat, rv, ev, bb, ib);
    model_apply(1, 32'h04, 32'hDEADBEEF);
    n_chk++;
    if (lat !== 3 || bb !== 0) begin
      n_fail++; $display("FAIL wr_latency: got lat=%0d busy_gaps=%0d want lat=3 gaps=0", lat, bb);
    end
    n_chk++;
    if (rv !== prev) begin
      n_fail++; $display("FAIL wr_rdata_hold: got %08h want %08h", rv, prev);
    end
    do_access(0, 1, 32'h04, 32'h0, 1, lat, rv, ev, bb, ib);
    model_apply(0, 32'h04, 32'h0);
    n_chk++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL rd_latency: got %0d want 3", lat);
    end
    n_chk++;
    if (rv !== 32'hDEADBEEF || ev !== 1'b0) begin
      n_fail++; $display("FAIL rd_data: got %08h err=%0b want DEADBEEF err=0", rv, ev);
    end
  endtask

  task automatic test_both_high();
    int lat, bb; logic [31:0] rv; logic ev, ib;
    logic [31:0] prev;
    prev = m_rdata;
    do_access(1, 1, 32'h08, 32'h12345678, 0, lat, rv, ev, bb, ib);
    model_apply(1, 32'h08, 32'h12345678);
    n_chk++;
    if (rv !== prev) begin
      n_fail++; $display("FAIL both_high_is_write: got rdata %08h want held %08h", rv, prev);
    end
    do_access(0, 1, 32'h08, 32'h0, 0, lat, rv, ev, bb, ib);
    model_apply(0, 32'h08, 32'h0);
    n_chk++;
    if (rv !== 32'h12345678) begin
      n_fail++; $display("FAIL both_high_readback: got %08h want 12345678", rv);
    end
  endtask

  // Read held high continuously: each access spans LAT+2 cycles
  // (accept, LAT waiting/completing edges, return to IDLE), with busy low
  // only in the IDLE cycle and mem_ready in the completion cycle.
  task automatic test_hold();
    int pulses;
    int ph;
    bit exp_busy, exp_rdy;
    @(negedge clk);
    bus.mem_read = 1; bus.addr = 32'h04;
    pulses = 0;
    for (int k = 0; k < 3 * (LAT + 2); k++) begin
      @(negedge clk);
      ph = k % (LAT + 2);
      exp_busy = (ph != LAT + 1);
      exp_rdy  = (ph == LAT);
      if (bus.mem_ready === 1'b1) pulses++;
      n_chk++;
      if (bus.busy !== exp_busy || bus.mem_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got busy=%0b rdy=%0b want busy=%0b rdy=%0b",
                 k, bus.busy, bus.mem_ready, exp_busy, exp_rdy);
      end
    end
    bus.mem_read = 0;
    model_apply(0, 32'h04, 32'h0);
    n_chk++;
    if (pulses !== 3 || bus.rdata !== m_rdata) begin
      n_fail++; $display("FAIL hold_pulses: got %0d rdata=%08h want 3 rdata=%08h",
                         pulses, bus.rdata, m_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_mode();
    int lat, bb; logic [31:0] rv; logic ev, ib;
`ifdef MEM_ACCESS_ERR_EN
    do_access(1, 0, 32'h000, 32'h11112222, 0, lat, rv, ev, bb, ib);
    model_apply(1, 32'h000, 32'h11112222);
    do_access(0, 1, 32'h06, 32'h0, 0, lat, rv, ev, bb, ib);
    n_chk++;
    if (ev !== 1'b1 || rv !== 32'd0 || lat !== LAT + 1) begin
      n_fail++; $display("FAIL err_misaligned: got err=%0b rdata=%08h lat=%0d want 1/0/%0d", ev, rv, lat, LAT + 1);
    end
    do_access(0, 1, 32'h400, 32'h0, 0, lat, rv, ev, bb, ib);
    n_chk++;
    if (ev !== 1'b1 || rv !== 32'd0) begin
      n_fail++; $display("FAIL err_range: got err=%0b rdata=%08h want 1/0", ev, rv);
    end
    m_rdata = 32'd0;
    do_access(1, 0, 32'h401, 32'hFFFF0000, 0, lat, rv, ev, bb, ib);
    model_apply(1, 32'h401, 32'hFFFF0000);
    n_chk++;
    if (ev !== 1'b1) begin
      n_fail++; $display("FAIL err_write: got err=%0b want 1", ev);
    end
    do_access(0, 1, 32'h000, 32'h0, 0, lat, rv, ev, bb, ib);
    model_apply(0, 32'h000, 32'h0);
    n_chk++;
    if (rv !== 32'h11112222 || ev !== 1'b0) begin
      n_fail++; $display("FAIL err_ram_unchanged: got %08h err=%0b want 11112222 err=0", rv, ev);
    end
`else
    do_access(1, 0, 32'h400, 32'hA5A5A5A5, 0, lat, rv, ev, bb, ib);
    model_apply(1, 32'h400, 32'hA5A5A5A5);
    n_chk++;
    if (ev !== 1'b0) begin
      n_fail++; $display("FAIL wrap_write_err: got %0b want 0", ev);
    end
    do_access(0, 1, 32'h000, 32'h0, 0, lat, rv, ev, bb, ib);
    model_apply(0, 32'h000, 32'h0);
    n_chk++;
    if (rv !== 32'hA5A5A5A5 || ev !== 1'b0) begin
      n_fail++; $display("FAIL wrap_read: got %08h err=%0b want A5A5A5A5 err=0", rv, ev);
    end
`endif
  endtask

  task automatic test_random();
    int lat, bb; logic [31:0] rv; logic ev, ib;
    bit wr, rd, known, scr;
    logic [31:0] a, wd, exp_rd;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0: begin wr = 1; rd = 0; end
        1: begin wr = 0; rd = 1; end
        default: begin wr = 1; rd = 1; end
      endcase
      if ($urandom_range(0, 3) != 0) a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      else a = $urandom;
      wd  = $urandom;
      scr = 1'($urandom_range(0, 1));
      do_access(wr, rd, a, wd, scr, lat, rv, ev, bb, ib);
      known = wr || addr_err(a) || m_vld[idx_of(a)];
      model_apply(wr, a, wd);
      exp_rd = m_rdata;
      n_chk++;
      if (lat !== LAT + 1 || bb !== 0 || ib !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_timing: got lat=%0d gaps=%0d idle_busy=%0b want %0d/0/0",
                           t, lat, bb, ib, LAT + 1);
      end
      n_chk++;
      if (ev !== addr_err(a)) begin
        n_fail++; $display("FAIL rand%0d_err: got %0b want %0b", t, ev, addr_err(a));
      end
      if (known) begin
        n_chk++;
        if (rv !== exp_rd) begin
          n_fail++; $display("FAIL rand%0d_rdata: got %08h want %08h", t, rv, exp_rd);
        end
      end
    end
  endtask

  initial begin
    foreach (m_vld[i]) m_vld[i] = 0;
    m_rdata = 32'd0;
    test_reset();
    test_write_read();
    test_both_high();
    test_hold();
    test_addr_mode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
